pch_carry_unit: RTL and testbench

- Program-counter high byte (PCH) of the 65C02 core; the receiving end of the PC-low carry handshake.
- Samples the level carry_to_pch from the PC-low byte and increments PCH once per carry event.
- Answers with carry_done, which the PC-low byte uses to drop carry_to_pch.
- Also handles PCH loads from the data bus, interrupt/reset vector page loads, and relative-branch page-cross fix-ups. Drives the high address byte and the data-bus image of PCH.

---
 rtl/pch_carry_unit.sv | 94 +++++++++
 tb/tb_pch_carry_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pch_carry_unit.sv
// Program-counter high byte of the 65C02 core: loads, vector page, branch page-cross
// fix-ups, and the receiving side of the PC-low carry handshake.
module pch_carry_unit #(
    parameter logic [7:0] RESET_PCH   = 8'h00,
    parameter logic [7:0] VECTOR_PAGE = 8'hFF,
    parameter int         ACK_TIMEOUT = 4
) (
    input  logic       fclk,
    input  logic       reset,
    input  logic       load_pch_db,
    input  logic       vector_load,
    input  logic       branch_fix,
    input  logic       branch_back,
    input  logic       carry_to_pch,
    output logic       carry_done,
    input  logic [7:0] db_in,
    output logic [7:0] db_out,
    output logic [7:0] address_high_out,
    output logic       pch_wrap,
    output logic       hs_error,
    output logic       busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACK  = 1'b1;

    localparam logic [7:0] TIMEOUT_CNT = 8'(ACK_TIMEOUT);

    logic [0:0] state;
    logic [7:0] pch;
    logic [7:0] ack_cnt;
    logic       higher_update;
    logic       carry_fire;

    assign higher_update = load_pch_db | vector_load | branch_fix;
    assign carry_fire    = (state == IDLE) && carry_to_pch && !higher_update;

    // Register-only outputs: the handshake flag is simply the ACK state.
    assign carry_done       = (state == ACK);
    assign busy             = (state == ACK);
    assign db_out           = pch;
    assign address_high_out = pch;

    always_ff @(posedge fclk) begin
        if (reset) begin
            pch      <= RESET_PCH;
            state    <= IDLE;
            ack_cnt  <= 8'h00;
            pch_wrap <= 1'b0;
            hs_error <= 1'b0;
        end else begin
            pch_wrap <= 1'b0;

            if (load_pch_db) begin
                pch <= db_in;
            end else if (vector_load) begin
                pch <= VECTOR_PAGE;
            end else if (branch_fix) begin
                pch <= branch_back ? pch - 8'd1 : pch + 8'd1;
            end else if (carry_fire) begin
                pch      <= pch + 8'd1;
                pch_wrap <= (pch == 8'hFF);
            end

            // A blocked carry stays pending because carry_to_pch is a level.
            case (state)
                IDLE: begin
                    ack_cnt <= 8'h00;
                    if (carry_fire) begin
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (!carry_to_pch) begin
                        state   <= IDLE;
                        ack_cnt <= 8'h00;
                    end else begin
                        if (ack_cnt != TIMEOUT_CNT) begin
                            ack_cnt <= ack_cnt + 8'd1;
                        end
                        if (ack_cnt >= TIMEOUT_CNT - 8'd1) begin
                            hs_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    ack_cnt <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pch_carry_unit.sv
// Scoreboard bench for pch_carry_unit: directed per-cycle vectors push expected
// post-edge state; a monitor pops and compares one entry after every clock edge.
module tb_pch_carry_unit;

    logic       fclk = 1'b0;
    logic       reset = 1'b0;
    logic       load_pch_db = 1'b0;
    logic       vector_load = 1'b0;
    logic       branch_fix = 1'b0;
    logic       branch_back = 1'b0;
    logic       carry_to_pch = 1'b0;
    logic [7:0] db_in = 8'h00;
    logic       carry_done;
    logic [7:0] db_out;
    logic [7:0] address_high_out;
    logic       pch_wrap;
    logic       hs_error;
    logic       busy;

    typedef struct {
        logic [7:0] pch;
        logic       done;
        logic       wrap;
        logic       err;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    pch_carry_unit #(
        .RESET_PCH  (8'h00),
        .VECTOR_PAGE(8'hFF),
        .ACK_TIMEOUT(4)
    ) dut (
        .fclk            (fclk),
        .reset           (reset),
        .load_pch_db     (load_pch_db),
        .vector_load     (vector_load),
        .branch_fix      (branch_fix),
        .branch_back     (branch_back),
        .carry_to_pch    (carry_to_pch),
        .carry_done      (carry_done),
        .db_in           (db_in),
        .db_out          (db_out),
        .address_high_out(address_high_out),
        .pch_wrap        (pch_wrap),
        .hs_error        (hs_error),
        .busy            (busy)
    );

    always #5 fclk = ~fclk;

    // Drive one cycle of inputs at the falling edge and queue the expected state after the next rising edge.
    task automatic apply_stimulus(input logic rst, input logic ld, input logic vec,
                                  input logic bf, input logic bb, input logic cy,
                                  input logic [7:0] db, input logic [7:0] e_pch,
                                  input logic e_done, input logic e_wrap,
                                  input logic e_err, input string nm);
        exp_t e;
        @(negedge fclk);
        reset        = rst;
        load_pch_db  = ld;
        vector_load  = vec;
        branch_fix   = bf;
        branch_back  = bb;
        carry_to_pch = cy;
        db_in        = db;
        e.pch  = e_pch;
        e.done = e_done;
        e.wrap = e_wrap;
        e.err  = e_err;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input exp_t e);
        checks++;
        if (db_out !== e.pch || address_high_out !== e.pch || carry_done !== e.done ||
            busy !== e.done || pch_wrap !== e.wrap || hs_error !== e.err) begin
            errors++;
            $display("[TB] FAIL %s: got pch=%h/%h done=%b busy=%b wrap=%b err=%b, expected pch=%h done=%b busy=%b wrap=%b err=%b",
                     e.name, db_out, address_high_out, carry_done, busy, pch_wrap, hs_error,
                     e.pch, e.done, e.done, e.wrap, e.err);
        end
    endtask

    // Monitor: one queued expectation per rising edge, sampled 1 time unit later.
    initial begin
        forever begin
            @(posedge fclk);
            #1;
            if (exp_q.size() > 0) begin
                check_output(exp_q.pop_front());
            end
        end
    end

    initial begin
        //               rst ld vec bf bb cy db     pch   dn wr er
        apply_stimulus(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, "reset_init");
        apply_stimulus(0, 1, 0, 0, 0, 0, 8'h5A, 8'h5A, 0, 0, 0, "load_5a");
        apply_stimulus(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, "reset_1");
        apply_stimulus(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, "reset_2");
        // Basic carry handshake.
        apply_stimulus(0, 1, 0, 0, 0, 0, 8'h12, 8'h12, 0, 0, 0, "load_12");
        apply_stimulus(0, 0, 0, 0, 0, 1, 8'h00, 8'h13, 1, 0, 0, "carry_inc");
        apply_stimulus(0, 0, 0, 0, 0, 1, 8'h00, 8'h13, 1, 0, 0, "carry_hold");
        apply_stimulus(0, 0, 0, 0, 0, 0, 8'h00, 8'h13, 0, 0, 0, "carry_release");
        apply_stimulus(0, 0, 0, 0, 0, 0, 8'h00, 8'h13, 0, 0, 0, "no_extra_inc");
        // Wrap and branch fix-ups.
        apply_stimulus(0, 1, 0, 0, 0, 0, 8'hFF, 8'hFF, 0, 0, 0, "load_ff");
        apply_stimulus(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 1, 1, 0, "wrap_inc");
        apply_stimulus(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, "wrap_pulse_end");
        apply_stimulus(0, 0, 0, 1, 1, 0, 8'h00, 8'hFF, 0, 0, 0, "branch_back_wrap");
        apply_stimulus(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, "branch_fwd_wrap");
        apply_stimulus(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, "branch_back_ignored");
        // Load beats a pending carry; carry follows on the next edge.
        apply_stimulus(0, 1, 0, 0, 0, 0, 8'h20, 8'h20, 0, 0, 0, "load_20");
        apply_stimulus(0, 1, 0, 0, 0, 1, 8'h80, 8'h80, 0, 0, 0, "prio_load_wins");
        apply_stimulus(0, 0, 0, 0, 0, 1, 8'h00, 8'h81, 1, 0, 0, "prio_carry_serviced");
        apply_stimulus(0, 0, 0, 0, 0, 0, 8'h00, 8'h81, 0, 0, 0, "prio_release");
        // Vector page, then updates during ACK.
        apply_stimulus(0, 0, 1, 0, 0, 0, 8'h00, 8'hFF, 0, 0, 0, "vector_load");
        apply_stimulus(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 1, 1, 0, "vector_carry_wrap");
        apply_stimulus(0, 1, 0, 0, 0, 1, 8'hC0, 8'hC0, 1, 0, 0, "load_in_ack");
        apply_stimulus(0, 0, 0, 1, 0, 1, 8'h00, 8'hC1, 1, 0, 0, "branch_in_ack");
        apply_stimulus(0, 0, 0, 0, 0, 0, 8'h00, 8'hC1, 0, 0, 0, "ack_release");
        apply_stimulus(0, 1, 1, 0, 0, 0, 8'h33, 8'h33, 0, 0, 0, "load_over_vector");
        apply_stimulus(0, 0, 1, 1, 1, 0, 8'h00, 8'hFF, 0, 0, 0, "vector_over_branch");
        // Handshake timeout with ACK_TIMEOUT = 4.
        apply_stimulus(0, 1, 0, 0, 0, 0, 8'h40, 8'h40, 0, 0, 0, "load_40");
        apply_stimulus(0, 0, 0, 0, 0, 1, 8'h00, 8'h41, 1, 0, 0, "to_enter_ack");
        apply_stimulus(0, 0, 0, 0, 0, 1, 8'h00, 8'h41, 1, 0, 0, "to_ack_1");
        apply_stimulus(0, 0, 0, 0, 0, 1, 8'h00, 8'h41, 1, 0, 0, "to_ack_2");
        apply_stimulus(0, 0, 0, 0, 0, 1, 8'h00, 8'h41, 1, 0, 0, "to_ack_3");
        apply_stimulus(0, 0, 0, 0, 0, 1, 8'h00, 8'h41, 1, 0, 1, "timeout_set");
        apply_stimulus(0, 0, 0, 0, 0, 1, 8'h00, 8'h41, 1, 0, 1, "timeout_hold");
        apply_stimulus(0, 0, 0, 0, 0, 0, 8'h00, 8'h41, 0, 0, 1, "err_sticky");
        apply_stimulus(0, 0, 0, 0, 0, 0, 8'h00, 8'h41, 0, 0, 1, "err_sticky_idle");
        // Reset in the middle of a handshake.
        apply_stimulus(0, 0, 0, 0, 0, 1, 8'h00, 8'h42, 1, 0, 1, "carry_before_reset");
        apply_stimulus(1, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, "reset_mid_ack");
        apply_stimulus(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, "after_reset");
        stim_done = 1'b1;
    end

    initial begin
        int wait_cycles;
        wait (stim_done);
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(negedge fclk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
